// File: rtl/leaf_out_arbiter.sv
// Round-robin scheduler sharing one leaf-to-BFT packet output among NUM_REQ sources.
// Holds and re-presents the granted packet while the BFT signals resend.
module leaf_out_arbiter #(
  parameter int unsigned PACKET_BITS = 49,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned REQ_BITS    = 2,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [PACKET_BITS*NUM_REQ-1:0] req_packet,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [PACKET_BITS-1:0]        dout,
  input  logic                          resend,
  output logic [REQ_BITS-1:0]           grant_id,
  output logic                          busy
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

  state_e                   state_q;
  logic [PACKET_BITS-1:0]   dout_q;
  logic [REQ_BITS-1:0]      grant_id_q;
  logic [REQ_BITS-1:0]      ptr_q;
  logic [7:0]               cnt_q;
  logic                     busy_q;

  logic                     capture;
  logic                     keep;
  logic                     win_vld;
  logic [REQ_BITS-1:0]      win_id;
  logic [REQ_BITS-1:0]      idx;
  logic [PACKET_BITS-1:0]   win_pkt;
  logic [REQ_BITS-1:0]      ptr_next;
  logic [7:0]               cnt_next;

  // A held packet blocks capture until the BFT stops asking for a resend.
  assign capture = (state_q == StIdle) || !resend;

  always_comb begin
    keep    = req_vld[grant_id_q] && (cnt_q < MaxBurst);
    win_vld = keep;
    win_id  = grant_id_q;
    idx     = '0;
    if (!keep) begin
      // Scan downwards so the closest source to ptr_q is written last and wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = REQ_BITS'((32'(ptr_q) + 32'(k)) % NUM_REQ);
        if (req_vld[idx]) begin
          win_vld = 1'b1;
          win_id  = idx;
        end
      end
    end
  end

  always_comb begin
    win_pkt                = req_packet[32'(win_id) * PACKET_BITS +: PACKET_BITS];
    win_pkt[PACKET_BITS-1] = 1'b1;
    ptr_next = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
    if (win_id == grant_id_q) begin
      cnt_next = (cnt_q == MaxBurst) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_next = 8'd1;
    end
  end

  always_comb begin
    req_ack = '0;
    if (reset && capture && win_vld) begin
      req_ack = NUM_REQ'(1) << win_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      dout_q     <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
    end else if (capture) begin
      if (win_vld) begin
        state_q    <= StSend;
        dout_q     <= win_pkt;
        grant_id_q <= win_id;
        ptr_q      <= ptr_next;
        cnt_q      <= cnt_next;
        busy_q     <= 1'b1;
      end else begin
        state_q <= StIdle;
        dout_q  <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end
    end else begin
      state_q <= StHold;
      busy_q  <= 1'b1;
    end
  end

  assign dout     = dout_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Round-robin scheduler that shares a single leaf-to-BFT packet output among NUM_REQ packet sources.
- Sources are the stream flow-control output path, the configuration reply path and the instruction-load status path.
- Handles BFT back-pressure (resend) by retransmitting the held packet unchanged.
- Bounds per-source occupancy with a burst limit.
- Sits between the packet producers and dout_leaf_interface2bft in the leaf interface.

Parameters:
- PACKET_BITS, 49: packet width. Bit PACKET_BITS-1 is the packet valid flag.
- NUM_REQ, 4: number of requesting sources, 2..8.
- REQ_BITS, 2: width of the source index, equal to clog2(NUM_REQ).
- MAX_BURST, 8: maximum consecutive grants to one source while another source is waiting, 1..255.

Ports:
- clk, input, 1: single clock; all state is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_vld, input, NUM_REQ: per-source packet-valid flags.
- req_packet, input, PACKET_BITS*NUM_REQ: source i occupies bits [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- req_ack, output, NUM_REQ: one-hot. High in the cycle a source's packet is captured.
- dout, output, PACKET_BITS: registered packet to the BFT. All zeros when idle.
- resend, input, 1: BFT did not accept the packet currently on dout.
- grant_id, output, REQ_BITS: index of the source whose packet is on dout. Registered.
- busy, output, 1: high when dout carries a valid packet.

Behaviour:
- Reset (reset low, asynchronous):
  - dout=0, grant_id=0, busy=0, state=IDLE.
  - Round-robin pointer ptr=0, burst counter cnt=0.
  - req_ack is forced 0 while reset is low. A reset mid-packet drops the held packet; it is not retransmitted.
- States:
  - IDLE: dout invalid.
  - SEND: dout holds a freshly captured packet.
  - HOLD: dout is being retransmitted.
- Capture condition: state==IDLE, or state in {SEND, HOLD} with resend==0.
  - HOLD also requires resend==0 to capture, so the packet is re-presented until resend is sampled low.
- Winner selection when capture is allowed:
  - If the last grantee g still has req_vld[g]=1 and cnt<MAX_BURST, g wins again.
  - Otherwise the winner is the first source with req_vld=1 scanning ptr, ptr+1, ... modulo NUM_REQ.
- On capture with a winner w (req_ack[w]=1, combinational in that cycle):
  - Next cycle: dout = req_packet[w] with the MSB forced to 1; grant_id=w; state=SEND.
  - ptr = (w+1) mod NUM_REQ.
  - cnt = cnt+1 if w equals the previous grantee, else cnt=1.
- Burst counter: saturates at MAX_BURST. The limit applies only if another source is valid; a sole requester is never starved of its own bandwidth.
- On capture with no winner: dout=0, state=IDLE, cnt=0, ptr unchanged.
- resend==1 with state in {SEND, HOLD}:
  - dout and grant_id hold, state=HOLD, all req_ack=0.
  - ptr and cnt are unchanged.
- resend==1 in IDLE is ignored.
- Throughput and latency:
  - 1 packet per cycle maximum.
  - Capture-to-dout latency is 1 cycle.
  - req_ack depends combinationally on req_vld, state, resend, ptr and cnt, never on req_packet.
- Source protocol: a source keeps req_vld and req_packet stable until it sees req_ack. It may present its next packet in the cycle after the ack.
- Simultaneous events: resend and a new req_vld in the same cycle → resend wins; the new request waits.
- busy = (state != IDLE), registered.
- grant_id is retained in IDLE; it is not cleared.

Test Plan:
- Sources 0 and 2 assert req_vld continuously from reset release with payloads 0x1_0000_0000_00A0 and 0x1_0000_0000_00C0, MAX_BURST=1 → dout alternates A0, C0, A0, C0 starting 1 cycle after the first ack; req_ack alternates 0001, 0100.
- Source 1 alone holds req_vld for 20 cycles, MAX_BURST=8 → 20 back-to-back acks, cnt saturates at 8, no bubbles on dout.
- Sources 1 and 3 both valid, MAX_BURST=4 → source 1 gets 4 grants, then source 3 gets 4 grants; grant_id sequence is 1,1,1,1,3,3,3,3.
- Packet 0x0_1234_5678_9ABC from source 0, then resend high for 3 cycles → dout holds 0x1_1234_5678_9ABC for 4 cycles total; req_ack stays 0 during resend; the next capture occurs in the cycle resend is sampled low.
- Reset pulsed low mid-burst with source 2 valid → dout, busy and req_ack go 0 immediately; after release the first grant goes to source 2 with ptr=0 scan order; cnt restarts at 1.
- All req_vld low while resend=1 in IDLE → dout stays 0, state stays IDLE, no ack.
